// File: rtl/audio_pcm_out2.sv
// Wishbone-fed stereo PCM player: 512-word sample FIFO drained once per sample tick
// into a pair of first-order sigma-delta modulators producing PDM bitstreams.
module audio_pcm_out2 #(
  parameter int TICK_DIV = 500
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  wb_addr,
  output logic [31:0] wb_rdata,
  input  logic [31:0] wb_wdata,
  input  logic        wb_we,
  input  logic        wb_cyc,
  output logic        wb_ack,
  input  logic        usb_sof,
  output logic        audio_l,
  output logic        audio_r
);

  localparam int CW = $clog2(TICK_DIV) + 1;

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  state_t state, state_next;

  logic [CW-1:0] tick_cnt;
  logic          tick;
  logic [15:0]   tpf_cnt, tpf_cap;
  logic          run, running, underrun, overflow, underrun_evt;
  logic          csr_wr, fifo_wr, push, pop, full, empty;
  logic [31:0]   mem [512];
  logic [8:0]    wr_ptr, rd_ptr;
  logic [9:0]    f_lvl;
  logic [31:0]   sample;
  logic [16:0]   acc_l, acc_r;
  logic [31:0]   rd_mux;

  // Tick fires when the down-counter wraps negative, giving a TICK_DIV-cycle period.
  assign tick = tick_cnt[CW-1];

  always_ff @(posedge clk) begin
    if (!rst_n)    tick_cnt <= '0;
    else if (tick) tick_cnt <= CW'(TICK_DIV - 2);
    else           tick_cnt <= tick_cnt - 1'b1;
  end

  // Tick count restarts on each SOF so tpf_cap holds ticks per USB frame.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tpf_cnt <= '0;
      tpf_cap <= '0;
    end else if (usb_sof) begin
      tpf_cap <= tpf_cnt;
      tpf_cnt <= {15'd0, tick};
    end else if (tick) begin
      tpf_cnt <= tpf_cnt + 16'd1;
    end
  end

  assign csr_wr  = wb_ack & wb_we & (wb_addr == 2'd0);
  assign fifo_wr = wb_ack & wb_we & (wb_addr == 2'd1);
  assign full    = (f_lvl == 10'd512);
  assign empty   = (f_lvl == 10'd0);
  assign push    = fifo_wr & ~full;
  assign pop     = tick & (state != IDLE) & ~empty;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wb_wdata;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      f_lvl  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 9'd1;
      if (pop)  rd_ptr <= rd_ptr + 9'd1;
      case ({push, pop})
        2'b10:   f_lvl <= f_lvl + 10'd1;
        2'b01:   f_lvl <= f_lvl - 10'd1;
        default: f_lvl <= f_lvl;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (run) state_next = RUN;
      RUN:     if (!run) state_next = FLUSH;
      FLUSH:   if (run) state_next = RUN;
               else if (tick && empty) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    running      = (state != IDLE);
    underrun_evt = tick & (state == RUN) & empty;
  end

  // A new underrun/overflow event takes priority over a clear in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      run      <= 1'b0;
      underrun <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (csr_wr) run <= wb_wdata[0];
      if (underrun_evt)                underrun <= 1'b1;
      else if (csr_wr && wb_wdata[2])  underrun <= 1'b0;
      if (fifo_wr && full)             overflow <= 1'b1;
      else if (csr_wr && wb_wdata[3])  overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n)                  sample <= '0;
    else if (state_next == IDLE) sample <= '0;
    else if (pop)                sample <= mem[rd_ptr];
  end

  // Offset-binary input makes a zero sample give exactly 50% ones density.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_l <= '0;
      acc_r <= '0;
    end else begin
      acc_l <= {1'b0, acc_l[15:0]} + {1'b0, sample[15:0]  ^ 16'h8000};
      acc_r <= {1'b0, acc_r[15:0]} + {1'b0, sample[31:16] ^ 16'h8000};
    end
  end

  assign audio_l = acc_l[16];
  assign audio_r = acc_r[16];

  always_comb begin
    rd_mux = '0;
    if (wb_addr == 2'd0)
      rd_mux = {tpf_cap, 2'b00, f_lvl, overflow, underrun, running, run};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wb_ack   <= 1'b0;
      wb_rdata <= '0;
    end else begin
      wb_ack   <= wb_cyc & ~wb_ack;
      wb_rdata <= (wb_cyc & ~wb_ack & ~wb_we) ? rd_mux : 32'd0;
    end
  end

endmodule

// File: tb/tb_audio_pcm_out2.sv
// Scoreboard-driven bench for audio_pcm_out2: bus protocol, FIFO levels, tick-paced
// playback, flush, overflow/underrun flags, PDM density and frame tick capture.
module tb_audio_pcm_out2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  wb_addr;
  logic [31:0] wb_rdata;
  logic [31:0] wb_wdata;
  logic        wb_we;
  logic        wb_cyc;
  logic        wb_ack;
  logic        usb_sof;
  logic        audio_l;
  logic        audio_r;

  int n_checks = 0;
  int n_fails  = 0;
  int cyc_cnt  = 0;
  logic [31:0] exp_q[$];

  audio_pcm_out2 #(.TICK_DIV(500)) dut (
    .clk(clk), .rst_n(rst_n), .wb_addr(wb_addr), .wb_rdata(wb_rdata),
    .wb_wdata(wb_wdata), .wb_we(wb_we), .wb_cyc(wb_cyc), .wb_ack(wb_ack),
    .usb_sof(usb_sof), .audio_l(audio_l), .audio_r(audio_r)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic wait_ack(input string name);
    int n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!wb_ack && n < 8);
    if (!wb_ack) begin
      n_checks++; n_fails++;
      $display("[TB] FAIL %s_ack_timeout: got ack=%b expected ack=1", name, wb_ack);
    end
  endtask

  task automatic wb_read(input logic [1:0] a, output logic [31:0] d);
    wb_addr = a; wb_we = 1'b0; wb_cyc = 1'b1;
    wait_ack("read");
    d = wb_rdata;
    wb_cyc = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic wb_write(input logic [1:0] a, input logic [31:0] d);
    wb_addr = a; wb_wdata = d; wb_we = 1'b1; wb_cyc = 1'b1;
    wait_ack("write");
    wb_cyc = 1'b0;
    @(posedge clk); #1;
    wb_we = 1'b0;
  endtask

  task automatic measure(input int n, output int ones_l, output int ones_r);
    ones_l = 0; ones_r = 0;
    repeat (n) begin
      @(posedge clk); #1;
      ones_l += int'(audio_l);
      ones_r += int'(audio_r);
    end
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic wait_lvl(input logic [9:0] target, input int budget);
    logic [31:0] d;
    int t0 = cyc_cnt;
    bit hit = 0;
    while (!hit && cyc_cnt - t0 < budget) begin
      wb_read(2'd0, d);
      hit = (d[13:4] == target);
    end
    if (!hit) begin
      n_checks++; n_fails++;
      $display("[TB] FAIL wait_lvl_timeout: got f_lvl=%0d expected f_lvl=%0d", d[13:4], target);
    end
  endtask

  task automatic test_reset();
    logic [31:0] d, e;
    int ol, orr;
    rst_n = 1'b0; wb_cyc = 1'b0; wb_we = 1'b0; wb_addr = '0; wb_wdata = '0; usb_sof = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({wb_ack, audio_l, audio_r} !== 3'b000 || wb_rdata !== 32'd0) begin
      n_fails++;
      $display("[TB] FAIL reset_outputs: got ack=%b l=%b r=%b rdata=%h expected all 0",
               wb_ack, audio_l, audio_r, wb_rdata);
    end
    rst_n = 1'b1;
    exp_q.push_back(32'h0);
    wb_read(2'd0, d);
    e = exp_q.pop_front();
    n_checks++;
    if (d !== e) begin n_fails++; $display("[TB] FAIL reset_csr: got %h expected %h", d, e); end
    measure(1000, ol, orr);
    n_checks++;
    if (ol < 499 || ol > 501 || orr < 499 || orr > 501) begin
      n_fails++;
      $display("[TB] FAIL idle_density: got l=%0d r=%0d expected 500 of 1000", ol, orr);
    end
  endtask

  task automatic test_fill();
    logic [31:0] d, e;
    int ol, orr;
    for (int i = 0; i < 3; i++) wb_write(2'd1, 32'h0100_0100 * (i + 1));
    exp_q.push_back(32'h0000_0030);
    wb_read(2'd0, d);
    e = exp_q.pop_front();
    n_checks++;
    if (d !== e) begin n_fails++; $display("[TB] FAIL fill_csr: got %h expected %h", d, e); end
    measure(1000, ol, orr);
    n_checks++;
    if (ol < 499 || ol > 501 || orr < 499 || orr > 501) begin
      n_fails++;
      $display("[TB] FAIL fill_density: got l=%0d r=%0d expected 500 of 1000", ol, orr);
    end
  endtask

  task automatic test_bus_protocol();
    logic [31:0] d, e;
    wb_write(2'd2, 32'hFFFF_FFFF);
    wb_write(2'd3, 32'hFFFF_FFFF);
    exp_q.push_back(32'h0000_0030);
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h0);
    for (int a = 0; a < 4; a++) begin
      wb_read(2'(a), d);
      e = exp_q.pop_front();
      n_checks++;
      if (d !== e) begin n_fails++; $display("[TB] FAIL read_addr%0d: got %h expected %h", a, d, e); end
    end
    wb_addr = 2'd0; wb_we = 1'b0; wb_cyc = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      n_checks++;
      if (wb_ack !== ((i % 2) == 0) || wb_rdata !== (((i % 2) == 0) ? 32'h30 : 32'h0)) begin
        n_fails++;
        $display("[TB] FAIL held_cyc_%0d: got ack=%b rdata=%h expected ack=%b rdata=%h",
                 i, wb_ack, wb_rdata, (i % 2) == 0, ((i % 2) == 0) ? 32'h30 : 32'h0);
      end
    end
    wb_cyc = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_playback();
    logic [31:0] d, e;
    logic [9:0] last_lvl = 10'd3;
    int t0, prev_t = -1;
    bit done = 0;
    exp_q.push_back(32'd2); exp_q.push_back(32'd1); exp_q.push_back(32'd0);
    wb_write(2'd0, 32'h1);
    t0 = cyc_cnt;
    while (!done && cyc_cnt - t0 < 3000) begin
      wb_read(2'd0, d);
      if (d[13:4] != last_lvl) begin
        last_lvl = d[13:4];
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fails++; $display("[TB] FAIL extra_pop: got f_lvl=%0d expected no change", d[13:4]);
        end else begin
          e = exp_q.pop_front();
          if (d[13:4] !== e[9:0]) begin
            n_fails++; $display("[TB] FAIL pop_lvl: got %0d expected %0d", d[13:4], e[9:0]);
          end
        end
        if (prev_t >= 0) begin
          n_checks++;
          if (cyc_cnt - prev_t != 500) begin
            n_fails++; $display("[TB] FAIL pop_interval: got %0d expected 500", cyc_cnt - prev_t);
          end
        end
        prev_t = cyc_cnt;
        n_checks++;
        if (d[1] !== 1'b1) begin n_fails++; $display("[TB] FAIL running_in_run: got %b expected 1", d[1]); end
      end
      if (d[2]) begin
        done = 1;
        n_checks++;
        if (exp_q.size() != 0 || last_lvl != 10'd0 || cyc_cnt - prev_t != 500) begin
          n_fails++;
          $display("[TB] FAIL underrun_timing: got lvl=%0d pending=%0d gap=%0d expected lvl=0 pending=0 gap=500",
                   last_lvl, exp_q.size(), cyc_cnt - prev_t);
        end
      end
    end
    if (!done) begin
      n_checks++; n_fails++;
      $display("[TB] FAIL underrun_timeout: got underrun=%b expected 1", d[2]);
    end
    exp_q.delete();
    wb_write(2'd0, 32'h0);
    repeat (600) @(posedge clk);
    #1;
    wb_write(2'd0, 32'h4);
    exp_q.push_back(32'h0);
    wb_read(2'd0, d);
    e = exp_q.pop_front();
    n_checks++;
    if (d !== e) begin n_fails++; $display("[TB] FAIL after_stop_csr: got %h expected %h", d, e); end
  endtask

  task automatic test_overflow();
    logic [31:0] d, e;
    for (int i = 0; i < 513; i++) wb_write(2'd1, 32'(i));
    exp_q.push_back(32'h0000_2008);
    exp_q.push_back(32'h0000_2000);
    exp_q.push_back(32'h0);
    wb_read(2'd0, d);
    e = exp_q.pop_front();
    n_checks++;
    if (d !== e) begin n_fails++; $display("[TB] FAIL overflow_set: got %h expected %h", d, e); end
    wb_write(2'd0, 32'h8);
    wb_read(2'd0, d);
    e = exp_q.pop_front();
    n_checks++;
    if (d !== e) begin n_fails++; $display("[TB] FAIL overflow_clear: got %h expected %h", d, e); end
    wb_write(2'd0, 32'h1);
    apply_reset();
    wb_read(2'd0, d);
    e = exp_q.pop_front();
    n_checks++;
    if (d !== e) begin n_fails++; $display("[TB] FAIL reset_mid_run: got %h expected %h", d, e); end
  endtask

  task automatic test_extremes();
    logic [31:0] d, e;
    int ol, orr;
    wb_write(2'd1, 32'h8000_7FFF);
    wb_write(2'd0, 32'h1);
    wait_lvl(10'd0, 800);
    repeat (4) @(posedge clk);
    #1;
    measure(2000, ol, orr);
    n_checks++;
    if (ol < 1990 || orr != 0) begin
      n_fails++;
      $display("[TB] FAIL fullscale_density: got l=%0d r=%0d expected l>=1990 r=0 of 2000", ol, orr);
    end
    wb_write(2'd0, 32'h0);
    repeat (1100) @(posedge clk);
    #1;
    exp_q.push_back(32'h0000_0004);
    wb_read(2'd0, d);
    e = exp_q.pop_front();
    n_checks++;
    if (d !== e) begin n_fails++; $display("[TB] FAIL extremes_idle_csr: got %h expected %h", d, e); end
    measure(1000, ol, orr);
    n_checks++;
    if (ol < 499 || ol > 501 || orr < 499 || orr > 501) begin
      n_fails++;
      $display("[TB] FAIL return_idle_density: got l=%0d r=%0d expected 500 of 1000", ol, orr);
    end
  endtask

  task automatic test_flush();
    logic [31:0] d, e;
    logic [9:0] last_lvl = 10'd2;
    int t0, prev_t = -1;
    bit done = 0;
    apply_reset();
    for (int i = 0; i < 3; i++) wb_write(2'd1, 32'h1234_0000 + 32'(i));
    wb_write(2'd0, 32'h1);
    wait_lvl(10'd2, 800);
    wb_write(2'd0, 32'h0);
    exp_q.push_back(32'h0000_0022);
    wb_read(2'd0, d);
    e = exp_q.pop_front();
    n_checks++;
    if (d !== e) begin n_fails++; $display("[TB] FAIL flush_entry_csr: got %h expected %h", d, e); end
    exp_q.push_back(32'd1); exp_q.push_back(32'd0);
    t0 = cyc_cnt;
    while (!done && cyc_cnt - t0 < 2000) begin
      wb_read(2'd0, d);
      if (d[13:4] != last_lvl) begin
        last_lvl = d[13:4];
        n_checks++;
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hFFFF_FFFF;
        if (d[13:4] !== e[9:0] || d[1] !== 1'b1) begin
          n_fails++;
          $display("[TB] FAIL flush_pop: got lvl=%0d running=%b expected lvl=%0d running=1", d[13:4], d[1], e[9:0]);
        end
        if (prev_t >= 0) begin
          n_checks++;
          if (cyc_cnt - prev_t != 500) begin
            n_fails++; $display("[TB] FAIL flush_interval: got %0d expected 500", cyc_cnt - prev_t);
          end
        end
        prev_t = cyc_cnt;
      end
      if (!d[1]) begin
        done = 1;
        n_checks++;
        if (exp_q.size() != 0 || cyc_cnt - prev_t != 500 || d !== 32'h0) begin
          n_fails++;
          $display("[TB] FAIL flush_to_idle: got csr=%h pending=%0d gap=%0d expected csr=0 pending=0 gap=500",
                   d, exp_q.size(), cyc_cnt - prev_t);
        end
      end
    end
    if (!done) begin
      n_checks++; n_fails++;
      $display("[TB] FAIL flush_timeout: got running=%b expected 0", d[1]);
    end
  endtask

  task automatic test_tpf();
    logic [31:0] d, e;
    for (int k = 0; k < 2; k++) begin
      usb_sof = 1'b1;
      @(posedge clk); #1;
      usb_sof = 1'b0;
      if (k == 0) repeat (23999) @(posedge clk);
      #1;
    end
    exp_q.push_back(32'd48);
    wb_read(2'd0, d);
    e = exp_q.pop_front();
    n_checks++;
    if (d[31:16] !== e[15:0]) begin n_fails++; $display("[TB] FAIL tpf_cap: got %0d expected %0d", d[31:16], e[15:0]); end
  endtask

  initial begin
    $display("[TB] starting audio_pcm_out2 bench");
    test_reset();
    test_fill();
    test_bus_protocol();
    test_playback();
    test_overflow();
    test_extremes();
    test_flush();
    test_tpf();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
